// File: rtl/sd_spi_card_responder.sv
// sd_spi_card_responder: SD card (SDHC, SPI mode) emulation behind a byte-level SPI slave.
// Decodes commands, answers R1/R3/R7, and streams CMD17 reads / CMD24 writes through a sector buffer port.
module sd_spi_card_responder #(
  parameter int NCR        = 1,
  parameter int INIT_COUNT = 2,
  parameter int READ_WAIT  = 4,
  parameter int BUSY_BYTES = 8
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_rx,
  output logic [7:0]  tx_byte,
  output logic        card_idle,
  output logic        blk_rd_req,
  input  logic        blk_rd_ready,
  input  logic [7:0]  blk_rd_data,
  output logic        blk_rd_pop,
  output logic        blk_wr_en,
  output logic [7:0]  blk_wr_data,
  output logic        blk_wr_done,
  output logic [31:0] blk_addr
);
  typedef enum logic [3:0] {S_CMD, S_NCR, S_R1, S_RESP_EXT, S_RD_WAIT, S_RD_DATA, S_RD_CRC,
                            S_WR_TOKEN, S_WR_DATA, S_WR_CRC, S_WR_BUSY} state_t;
  typedef enum logic [1:0] {K_R1, K_EXT, K_RD, K_WR} kind_t;
  localparam logic [3:0] NCR_L  = 4'(NCR - 1);
  localparam logic [3:0] RW_L   = 4'(READ_WAIT - 1);
  localparam logic [3:0] BUSY_L = 4'(BUSY_BYTES);
  localparam logic [7:0] INIT_L = 8'(INIT_COUNT);
  state_t state_q, state_d;
  kind_t kind_q, kind_d;
  logic [7:0] tx_q, tx_d, acnt_q, acnt_d, wr_data_q, wr_data_d;
  logic idle_q, idle_d, app_q, app_d;
  logic rd_req_q, rd_req_d, wr_en_q, wr_en_d, wr_done_q, wr_done_d;
  logic [9:0] dcnt_q, dcnt_d;
  logic [3:0] scnt_q, scnt_d;
  logic [37:0] cmd_q, cmd_d;  // index (6 bits) followed by the 32-bit argument
  logic [31:0] ext_q, ext_d, addr_q, addr_d;
  logic [5:0] idx;
  logic [31:0] arg;
  logic [7:0] r1;
  assign idx = cmd_q[37:32];
  assign arg = cmd_q[31:0];
  assign r1 = {7'b0, idle_q};
  always_comb begin
    state_d = state_q;
    kind_d = kind_q;
    tx_d = tx_q;
    idle_d = idle_q;
    app_d = app_q;
    acnt_d = acnt_q;
    dcnt_d = dcnt_q;
    scnt_d = scnt_q;
    cmd_d = cmd_q;
    ext_d = ext_q;
    addr_d = addr_q;
    wr_data_d = wr_data_q;
    rd_req_d = 1'b0;
    wr_en_d = 1'b0;
    wr_done_d = 1'b0;
    blk_rd_pop = 1'b0;
    if (cs_n) begin
      state_d = S_CMD;
      tx_d = 8'hFF;
      scnt_d = '0;
      dcnt_d = '0;
    end else if (byte_valid) begin
      case (state_q)
        S_CMD: if (scnt_q != 4'd0 || byte_rx[7:6] == 2'b01) begin
          if (scnt_q == 4'd5) begin
            state_d = S_NCR;
            scnt_d = '0;
          end else begin
            cmd_d = {cmd_q[29:0], byte_rx};
            scnt_d = scnt_q + 4'd1;
          end
        end
        S_NCR: if (scnt_q == NCR_L) begin
          state_d = S_R1;
          scnt_d = '0;
          kind_d = K_R1;
          app_d = 1'b0;
          tx_d = r1 | 8'h04;
          if (idx == 6'd0) begin
            tx_d = 8'h01;
            idle_d = 1'b1;
            acnt_d = '0;
          end else if (idx == 6'd8) begin
            tx_d = r1;
            kind_d = K_EXT;
            ext_d = {20'h0, arg[11:0]};
          end else if (idx == 6'd55) begin
            tx_d = r1;
            app_d = 1'b1;
          end else if (idx == 6'd41 && app_q) begin
            tx_d = acnt_q < INIT_L ? 8'h01 : 8'h00;
            acnt_d = acnt_q < INIT_L ? acnt_q + 8'd1 : acnt_q;
            idle_d = acnt_q < INIT_L ? idle_q : 1'b0;
          end else if (idx == 6'd58) begin
            tx_d = r1;
            kind_d = K_EXT;
            ext_d = 32'hC0FF_8000;
          end else if (idx == 6'd16) begin
            tx_d = r1;
          end else if ((idx == 6'd17 || idx == 6'd24) && !idle_q) begin
            tx_d = 8'h00;
            addr_d = arg;
            kind_d = idx == 6'd17 ? K_RD : K_WR;
            rd_req_d = idx == 6'd17;
          end
        end else scnt_d = scnt_q + 4'd1;
        S_R1: begin
          scnt_d = '0;
          dcnt_d = '0;
          state_d = kind_q == K_EXT ? S_RESP_EXT : kind_q == K_RD ? S_RD_WAIT : kind_q == K_WR ? S_WR_TOKEN : S_CMD;
          tx_d = kind_q == K_EXT ? ext_q[31:24] : 8'hFF;
          ext_d = ext_q << 8;
        end
        S_RESP_EXT: begin
          tx_d = scnt_q == 4'd3 ? 8'hFF : ext_q[31:24];
          ext_d = ext_q << 8;
          state_d = scnt_q == 4'd3 ? S_CMD : S_RESP_EXT;
          scnt_d = scnt_q == 4'd3 ? 4'd0 : scnt_q + 4'd1;
        end
        S_RD_WAIT: if (scnt_q >= RW_L && blk_rd_ready) begin
          tx_d = 8'hFE;
          state_d = S_RD_DATA;
          scnt_d = '0;
          dcnt_d = '0;
        end else begin
          tx_d = 8'hFF;
          scnt_d = scnt_q < RW_L ? scnt_q + 4'd1 : scnt_q;
        end
        // A starved buffer sends 0xFF without counting rather than underrunning
        S_RD_DATA: if (blk_rd_ready) begin
          tx_d = blk_rd_data;
          blk_rd_pop = 1'b1;
          state_d = dcnt_q == 10'd511 ? S_RD_CRC : S_RD_DATA;
          dcnt_d = dcnt_q == 10'd511 ? 10'd0 : dcnt_q + 10'd1;
          scnt_d = '0;
        end else tx_d = 8'hFF;
        S_RD_CRC: begin
          tx_d = 8'hFF;
          state_d = scnt_q == 4'd1 ? S_CMD : S_RD_CRC;
          scnt_d = scnt_q == 4'd1 ? 4'd0 : scnt_q + 4'd1;
        end
        S_WR_TOKEN: if (byte_rx == 8'hFE) begin
          state_d = S_WR_DATA;
          dcnt_d = '0;
        end
        S_WR_DATA: begin
          wr_en_d = 1'b1;
          wr_data_d = byte_rx;
          state_d = dcnt_q == 10'd511 ? S_WR_CRC : S_WR_DATA;
          dcnt_d = dcnt_q == 10'd511 ? 10'd0 : dcnt_q + 10'd1;
          scnt_d = '0;
        end
        S_WR_CRC: if (scnt_q == 4'd1) begin
          tx_d = 8'h05;
          wr_done_d = 1'b1;
          state_d = S_WR_BUSY;
          scnt_d = '0;
        end else scnt_d = scnt_q + 4'd1;
        S_WR_BUSY: begin
          tx_d = scnt_q == BUSY_L ? 8'hFF : 8'h00;
          state_d = scnt_q == BUSY_L ? S_CMD : S_WR_BUSY;
          scnt_d = scnt_q == BUSY_L ? 4'd0 : scnt_q + 4'd1;
        end
        default: state_d = S_CMD;
      endcase
    end
  end
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= S_CMD;
      kind_q <= K_R1;
      tx_q <= 8'hFF;
      idle_q <= 1'b1;
      app_q <= 1'b0;
      acnt_q <= '0;
      dcnt_q <= '0;
      scnt_q <= '0;
      cmd_q <= '0;
      ext_q <= '0;
      addr_q <= '0;
      wr_data_q <= '0;
      rd_req_q <= 1'b0;
      wr_en_q <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q <= kind_d;
      tx_q <= tx_d;
      idle_q <= idle_d;
      app_q <= app_d;
      acnt_q <= acnt_d;
      dcnt_q <= dcnt_d;
      scnt_q <= scnt_d;
      cmd_q <= cmd_d;
      ext_q <= ext_d;
      addr_q <= addr_d;
      wr_data_q <= wr_data_d;
      rd_req_q <= rd_req_d;
      wr_en_q <= wr_en_d;
      wr_done_q <= wr_done_d;
    end
  end
  assign tx_byte = tx_q;
  assign card_idle = idle_q;
  assign blk_addr = addr_q;
  assign blk_rd_req = rd_req_q;
  assign blk_wr_en = wr_en_q;
  assign blk_wr_data = wr_data_q;
  assign blk_wr_done = wr_done_q;
endmodule
